part_2_clk_sched: RTL and testbench
===================================

// Module: part_2_clk_sched
// PURPOSE
//  Round-robin scheduler for the mission-clock domains of a co-simulation target.
//  Serves one domain at a time: sends its vector to the peer (put), waits for the reply (get),
//  then releases that domain's clock for one cycle. All other domains stay frozen.
//  A watchdog bounds the wait for the reply. Sits between the clock-edge detectors and the fringe transport.
// PARAMETERS
//  N         4      number of mission-clock domains
//  IDX_W     2      index width, $clog2(N) (minimum 1)
//  WDOG_MAX  10000  cycles spent in GET before a timeout
//  WDOG_W    14     watchdog counter width; must hold WDOG_MAX
// PORTS
//  clk_i         in   1      utility clock; sole clock of the block
//  rst_i         in   1      synchronous reset, active-high
//  req_i         in   N      1-cycle pulse per domain: a mission-clock edge was detected
//  put_en_i      in   1      enable the SEND phase (vector export)
//  get_en_i      in   1      enable the GET phase (wait for the peer reply)
//  put_req_o     out  1      request to send the vector of domain put_idx_o
//  put_idx_o     out  IDX_W  domain index for the put and get phases
//  put_ack_i     in   1      transport accepted the put
//  get_valid_i   in   1      transport received a payload
//  get_idx_i     in   IDX_W  domain index of the received payload
//  freeze_clk_o  out  N      1 = domain clock blocked
//  grant_o       out  N      one-hot: domain being served; all zero in IDLE
//  busy_o        out  1      FSM is not in IDLE
//  wdog_err_o    out  1      sticky timeout flag
// BEHAVIOUR
//  Reset values
//   - freeze_clk_o = all ones; grant_o = 0; put_req_o = 0; put_idx_o = 0; busy_o = 0; wdog_err_o = 0.
//   - pending = 0; rr_ptr = N-1; wdog = 0.
//  pending[N] register
//   - set by req_i; clear of bit sel happens in REL.
//   - A req_i on bit sel in the same cycle as the REL clear wins: the bit stays set.
//   - Repeated requests on a bit that is already pending merge into one; there is no counting.
//  FSM state IDLE
//   - If pending != 0: sel = first set bit scanning rr_ptr+1 .. rr_ptr+N, modulo N.
//   - Next state: SEND if put_en_i; else GET if get_en_i; else REL.
//   - A request arriving in the IDLE cycle is not visible to the selection until the next cycle.
//  FSM state SEND
//   - put_req_o = 1 and put_idx_o = sel, both held stable until put_ack_i.
//   - The transfer completes in the cycle where put_req_o and put_ack_i are both 1.
//   - Next state on completion: GET if get_en_i, else REL.
//  FSM state GET
//   - wdog increments every cycle.
//   - get_valid_i with get_idx_i == sel: go to REL and clear wdog.
//   - get_valid_i with a different index is ignored; it is not buffered.
//   - wdog reaching WDOG_MAX-1 with no match: go to ERR.
//  FSM state REL
//   - freeze_clk_o[sel] = 0 for exactly this one cycle.
//   - Clear pending[sel]; rr_ptr = sel; next state IDLE.
//  FSM state ERR
//   - wdog_err_o = 1; freeze_clk_o = all ones; put_req_o = 0.
//   - Terminal: only rst_i leaves it.
//  Outputs and timing
//   - grant_o = onehot(sel) in SEND, GET, REL and ERR; 0 in IDLE.
//   - Every output is registered.
//   - Minimum latency from req_i to clock release: 3 cycles (req, IDLE, REL) with put and get disabled.
//   - put_en_i and get_en_i are sampled only at the transitions listed above; changes mid-phase have no effect.
//  Reset mid-operation
//   - put_req_o drops in the next cycle; pending requests are discarded.
//   - The transport must tolerate a put request that is abandoned.
// CONFIGURATION
//  Macro SCHED_STATS_EN
//  - Defined: adds output xfer_cnt_o[15:0] and output max_wait_o[WDOG_W-1:0].
//    - xfer_cnt_o counts REL cycles and wraps at 16 bits.
//    - max_wait_o holds the largest wdog value at GET exit.
//    - Both reset to 0.
//  - Undefined: neither port nor any of its logic exists; the rest of the behaviour is identical.
// TESTING
//  T1  N=4, put and get enabled
//      - req_i = 4'b0010; ack after 2 cycles; get_valid with idx 1 after 5 cycles.
//      - Required: freeze_clk_o = 4'b1101 for exactly one cycle, then 4'b1111; busy_o falls.
//  T2  req_i = 4'b1111 in one cycle, rr_ptr = 3
//      - Required: service order 0, 1, 2, 3.
//      - Required: 4 separate single-cycle releases and no starvation.
//  T3  GET with only mismatched get_idx_i, WDOG_MAX = 16
//      - Required: wdog_err_o rises exactly 16 cycles after GET entry.
//      - Required: freeze_clk_o = all ones; stays latched until rst_i.
//  T4  put_en_i = 0, get_en_i = 0, req_i on domain 2
//      - Required: release 2 cycles after the pulse; put_req_o is never asserted.
//  T5  rst_i asserted while in SEND
//      - Required: the next cycle shows all reset values and pending = 0.
//      - A new request is served normally after reset.
//  T6  SCHED_STATS_EN defined; 3 transfers with GET waits of 4, 9 and 2 cycles
//      - Required: xfer_cnt_o = 3 and max_wait_o = 9.

Source files
------------

// File: rtl/part_2_clk_sched_if.sv
// part_2_clk_sched_if -- put/get transport handshake between the clock scheduler
// (master) and the fringe transport (slave). Signal names carry the scheduler's
// point of view for direction suffixes.
`timescale 1ns/1ps
interface part_2_clk_sched_if #(
  parameter int IDX_W = 2
);
  logic             put_req_o;
  logic [IDX_W-1:0] put_idx_o;
  logic             put_ack_i;
  logic             get_valid_i;
  logic [IDX_W-1:0] get_idx_i;

  modport master (
    output put_req_o, put_idx_o,
    input  put_ack_i, get_valid_i, get_idx_i
  );

  modport slave (
    input  put_req_o, put_idx_o,
    output put_ack_i, get_valid_i, get_idx_i
  );
endinterface

// File: rtl/part_2_clk_sched.sv
// part_2_clk_sched -- round-robin scheduler for co-simulation mission clocks.
// Serves one pending domain at a time: SEND its vector, wait in GET for the
// peer reply (watchdog bounded), then release that domain's clock for one cycle.
// Optional feature: define SCHED_STATS_EN to add the xfer_cnt_o / max_wait_o
// statistics outputs; without it those ports and their logic do not exist.
`timescale 1ns/1ps
module part_2_clk_sched #(
  parameter int N        = 4,
  parameter int IDX_W    = 2,
  parameter int WDOG_MAX = 10000,
  parameter int WDOG_W   = 14
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [N-1:0]       req_i,
  input  logic               put_en_i,
  input  logic               get_en_i,
  part_2_clk_sched_if.master xfer_if,
  output logic [N-1:0]       freeze_clk_o,
  output logic [N-1:0]       grant_o,
  output logic               busy_o,
  output logic               wdog_err_o
`ifdef SCHED_STATS_EN
  ,
  output logic [15:0]        xfer_cnt_o,
  output logic [WDOG_W-1:0]  max_wait_o
`endif
);

  typedef enum logic [2:0] {S_IDLE, S_SEND, S_GET, S_REL, S_ERR} state_t;

  state_t            state_q;
  logic [N-1:0]      pending_q, pending_d;
  logic [IDX_W-1:0]  rr_ptr_q;
  logic [IDX_W-1:0]  sel_q, sel_d;
  logic              found_d;
  logic [WDOG_W-1:0] wdog_q;
  logic [N-1:0]      freeze_q, grant_q;
  logic              put_req_q;
  logic [IDX_W-1:0]  put_idx_q;
  logic              busy_q, err_q;
  logic              get_match, wdog_done;
  int                cand;

  function automatic logic [N-1:0] onehot(input logic [IDX_W-1:0] idx);
    return N'(1) << idx;
  endfunction

  assign get_match = xfer_if.get_valid_i && (xfer_if.get_idx_i == sel_q);
  assign wdog_done = (wdog_q == WDOG_W'(WDOG_MAX - 1));

  // Round-robin pick: first pending domain after the last one served.
  always_comb begin
    // NOTE: combinational blocks use blocking '=' and give every output a default first, so no latch is inferred.
    found_d = 1'b0;
    sel_d   = '0;
    cand    = 0;
    for (int k = 1; k <= N; k++) begin
      cand = int'(rr_ptr_q) + k;
      if (cand >= N) cand = cand - N;
      if (!found_d && pending_q[cand[IDX_W-1:0]]) begin
        found_d = 1'b1;
        sel_d   = cand[IDX_W-1:0];
      end
    end
  end

  // Pending set: cleared for the served domain in REL; a same-cycle request wins.
  always_comb begin
    pending_d = pending_q;
    if (state_q == S_REL) pending_d = pending_d & ~onehot(sel_q);
    pending_d = pending_d | req_i;
  end

  // Scheduler FSM with all outputs registered alongside the state.
  always_ff @(posedge clk_i) begin
    // NOTE: reset is synchronous; every register here, including pending, is cleared in that same clocked branch.
    if (rst_i) begin
      state_q   <= S_IDLE;
      pending_q <= '0;
      rr_ptr_q  <= IDX_W'(N - 1);
      sel_q     <= '0;
      wdog_q    <= '0;
      freeze_q  <= '1;
      grant_q   <= '0;
      put_req_q <= 1'b0;
      put_idx_q <= '0;
      busy_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking '<=' so every register sees pre-edge values.
      pending_q <= pending_d;
      case (state_q)
        S_IDLE: begin
          if (found_d) begin
            sel_q     <= sel_d;
            put_idx_q <= sel_d;
            grant_q   <= onehot(sel_d);
            busy_q    <= 1'b1;
            if (put_en_i) begin
              state_q   <= S_SEND;
              put_req_q <= 1'b1;
            end else if (get_en_i) begin
              state_q <= S_GET;
              wdog_q  <= '0;
            end else begin
              state_q  <= S_REL;
              freeze_q <= ~onehot(sel_d);
            end
          end
        end
        S_SEND: begin
          if (put_ack_i_seen()) begin
            put_req_q <= 1'b0;
            if (get_en_i) begin
              state_q <= S_GET;
              wdog_q  <= '0;
            end else begin
              state_q  <= S_REL;
              freeze_q <= ~onehot(sel_q);
            end
          end
        end
        S_GET: begin
          if (get_match) begin
            state_q  <= S_REL;
            freeze_q <= ~onehot(sel_q);
            wdog_q   <= '0;
          end else if (wdog_done) begin
            state_q  <= S_ERR;
            err_q    <= 1'b1;
            freeze_q <= '1;
            put_req_q <= 1'b0;
          end else begin
            wdog_q <= wdog_q + 1'b1;
          end
        end
        S_REL: begin
          state_q  <= S_IDLE;
          rr_ptr_q <= sel_q;
          freeze_q <= '1;
          grant_q  <= '0;
          busy_q   <= 1'b0;
        end
        S_ERR: begin
          state_q <= S_ERR;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // The put completes when the registered request meets the transport ack.
  function automatic logic put_ack_i_seen();
    return put_req_q && xfer_if.put_ack_i;
  endfunction

  assign xfer_if.put_req_o = put_req_q;
  assign xfer_if.put_idx_o = put_idx_q;
  assign freeze_clk_o      = freeze_q;
  assign grant_o           = grant_q;
  assign busy_o            = busy_q;
  assign wdog_err_o        = err_q;

`ifdef SCHED_STATS_EN
  logic [15:0]       xfer_cnt_q;
  logic [WDOG_W-1:0] max_wait_q;

  // Count clock releases and keep the longest GET wait seen at GET exit.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      xfer_cnt_q <= '0;
      max_wait_q <= '0;
    end else begin
      if (state_q == S_REL) xfer_cnt_q <= xfer_cnt_q + 16'd1;
      if (state_q == S_GET && (get_match || wdog_done) && (wdog_q > max_wait_q))
        max_wait_q <= wdog_q;
    end
  end

  assign xfer_cnt_o = xfer_cnt_q;
  assign max_wait_o = max_wait_q;
`endif

endmodule

// File: tb/tb_part_2_clk_sched.sv
// tb_part_2_clk_sched -- randomized and directed bench for part_2_clk_sched.
// The reference model works on service timelines: for each service it finds
// the selection cycle, the ack cycle, the matching reply or timeout cycle and
// the release cycle from the stimulus tables, then fills per-cycle expectations.
`timescale 1ns/1ps
module tb_part_2_clk_sched;
  localparam int N        = 4;
  localparam int IDX_W    = 2;
  localparam int WDOG_MAX = 16;
  localparam int WDOG_W   = 5;
  localparam int MAXL     = 400;

  logic             clk_i = 1'b0;
  logic             rst_i;
  logic [N-1:0]     req_i;
  logic             put_en_i, get_en_i;
  logic [N-1:0]     freeze_clk_o, grant_o;
  logic             busy_o, wdog_err_o;
`ifdef SCHED_STATS_EN
  logic [15:0]       xfer_cnt_o;
  logic [WDOG_W-1:0] max_wait_o;
`endif

  part_2_clk_sched_if #(.IDX_W(IDX_W)) xif();

  part_2_clk_sched #(
    .N(N), .IDX_W(IDX_W), .WDOG_MAX(WDOG_MAX), .WDOG_W(WDOG_W)
  ) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .req_i        (req_i),
    .put_en_i     (put_en_i),
    .get_en_i     (get_en_i),
    .xfer_if      (xif.master),
    .freeze_clk_o (freeze_clk_o),
    .grant_o      (grant_o),
    .busy_o       (busy_o),
    .wdog_err_o   (wdog_err_o)
`ifdef SCHED_STATS_EN
    ,
    .xfer_cnt_o   (xfer_cnt_o),
    .max_wait_o   (max_wait_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  // Stimulus tables, one entry per cycle of a segment.
  logic [N-1:0]     s_req [MAXL];
  bit               s_pe [MAXL], s_ge [MAXL], s_ack [MAXL], s_gv [MAXL];
  logic [IDX_W-1:0] s_gi [MAXL];

  // Expected outputs per cycle.
  logic [N-1:0]     e_freeze [MAXL], e_grant [MAXL];
  bit               e_busy [MAXL], e_err [MAXL], e_preq [MAXL];
  logic [IDX_W-1:0] e_pidx [MAXL];
  int               e_xcnt [MAXL], e_maxw [MAXL];
  int               inc_x [MAXL], gx [MAXL];

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;
  bit check_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, exp);
    end
  endtask

  // Domain d is pending at cycle t if it requested in [from, t-1].
  function automatic bit is_pending(input int d, input int t, input int from);
    for (int c = from; c < t; c++)
      if (s_req[c][d]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic mark(input int c, input int s, input bit preq);
    e_busy[c]  = 1'b1;
    e_grant[c] = N'(1) << s;
    e_pidx[c]  = IDX_W'(s);
    e_preq[c]  = preq;
  endtask

  task automatic build_expected(input int len);
    int last_rel [N];
    int rr, t, s, d, ph, dec, a, m, rel, x, mw;
    bit found, matched, stop;
    for (int c = 0; c < len; c++) begin
      e_freeze[c] = '1; e_grant[c] = '0; e_busy[c] = 1'b0; e_err[c] = 1'b0;
      e_preq[c] = 1'b0; e_pidx[c] = '0; inc_x[c] = 0; gx[c] = -1;
    end
    for (int i = 0; i < N; i++) last_rel[i] = 0;
    rr = N - 1; t = 0; stop = 1'b0; rel = 0;
    while (!stop && t < len) begin
      found = 1'b0; s = 0;
      for (int k = 1; k <= N; k++) begin
        d = (rr + k) % N;
        if (!found && is_pending(d, t, last_rel[d])) begin
          found = 1'b1; s = d;
        end
      end
      if (!found) begin
        t++;
      end else begin
        ph = t + 1; dec = t;
        if (s_pe[t]) begin
          a = ph;
          while (a < len && !s_ack[a]) begin mark(a, s, 1'b1); a++; end
          if (a >= len) stop = 1'b1;
          else begin mark(a, s, 1'b1); dec = a; ph = a + 1; end
        end
        if (!stop) begin
          if (s_ge[dec]) begin
            matched = 1'b0; m = ph;
            while (!matched && m < ph + WDOG_MAX && m < len) begin
              mark(m, s, 1'b0);
              if (s_gv[m] && s_gi[m] == IDX_W'(s)) matched = 1'b1;
              else m++;
            end
            if (matched) begin
              gx[m] = m - ph; rel = m + 1;
            end else begin
              stop = 1'b1;
              if (m == ph + WDOG_MAX) begin
                gx[m-1] = WDOG_MAX - 1;
                for (int c = m; c < len; c++) begin mark(c, s, 1'b0); e_err[c] = 1'b1; end
              end
            end
          end else begin
            rel = ph;
          end
        end
        if (!stop) begin
          if (rel < len) begin
            mark(rel, s, 1'b0);
            e_freeze[rel] = ~(N'(1) << s);
            inc_x[rel] = 1; last_rel[s] = rel; rr = s; t = rel + 1;
          end else begin
            stop = 1'b1;
          end
        end
      end
    end
    x = 0; mw = 0;
    for (int c = 0; c < len; c++) begin
      e_xcnt[c] = x; e_maxw[c] = mw;
      if (inc_x[c] != 0) x = (x + 1) % 65536;
      if (gx[c] > mw) mw = gx[c];
    end
  endtask

  task automatic clear_stim(input int len);
    for (int c = 0; c < len; c++) begin
      s_req[c] = '0; s_pe[c] = 1'b0; s_ge[c] = 1'b0; s_ack[c] = 1'b0; s_gv[c] = 1'b0; s_gi[c] = '0;
    end
  endtask

  task automatic gen_random(input int len);
    int dens, pep, gep, ackp, gvp;
    dens = $urandom_range(3, 30); pep = $urandom_range(0, 9); gep = $urandom_range(0, 9);
    ackp = $urandom_range(2, 9); gvp = $urandom_range(3, 9);
    for (int c = 0; c < len; c++) begin
      s_req[c] = '0;
      for (int i = 0; i < N; i++) if ($urandom_range(0, 99) < dens) s_req[c][i] = 1'b1;
      s_pe[c]  = ($urandom_range(0, 9) < pep);
      s_ge[c]  = ($urandom_range(0, 9) < gep);
      s_ack[c] = ($urandom_range(0, 9) < ackp);
      s_gv[c]  = ($urandom_range(0, 9) < gvp);
      s_gi[c]  = IDX_W'($urandom_range(0, N - 1));
    end
  endtask

  // Called just after a rising edge; the following cycle must show reset values.
  task automatic apply_reset();
    check_en = 1'b0;
    rst_i = 1'b1; req_i = '0; put_en_i = 1'b0; get_en_i = 1'b0;
    xif.put_ack_i = 1'b0; xif.get_valid_i = 1'b0; xif.get_idx_i = '0;
    @(posedge clk_i);
    @(negedge clk_i);
    check("rst_freeze", 32'(freeze_clk_o), 32'(4'hF));
    check("rst_grant", 32'(grant_o), 32'(0));
    check("rst_put_req", 32'(xif.put_req_o), 32'(0));
    check("rst_put_idx", 32'(xif.put_idx_o), 32'(0));
    check("rst_busy", 32'(busy_o), 32'(0));
    check("rst_wdog_err", 32'(wdog_err_o), 32'(0));
  endtask

  task automatic run_segment(input int len);
    build_expected(len);
    for (int t = 0; t < len; t++) begin
      @(posedge clk_i); #1;
      rst_i = 1'b0; cyc = t; check_en = 1'b1;
      req_i = s_req[t]; put_en_i = s_pe[t]; get_en_i = s_ge[t];
      xif.put_ack_i = s_ack[t]; xif.get_valid_i = s_gv[t]; xif.get_idx_i = s_gi[t];
    end
    @(posedge clk_i); #1;
    apply_reset();
  endtask

  // Single compare process: DUT outputs against the model, mid-cycle.
  always @(negedge clk_i) begin
    if (check_en) begin
      check("freeze_clk", 32'(freeze_clk_o), 32'(e_freeze[cyc]));
      check("grant", 32'(grant_o), 32'(e_grant[cyc]));
      check("busy", 32'(busy_o), 32'(e_busy[cyc]));
      check("wdog_err", 32'(wdog_err_o), 32'(e_err[cyc]));
      check("put_req", 32'(xif.put_req_o), 32'(e_preq[cyc]));
      if (e_preq[cyc]) check("put_idx", 32'(xif.put_idx_o), 32'(e_pidx[cyc]));
`ifdef SCHED_STATS_EN
      check("xfer_cnt", 32'(xfer_cnt_o), 32'(e_xcnt[cyc]));
      check("max_wait", 32'(max_wait_o), 32'(e_maxw[cyc]));
`endif
    end
  end

  initial begin
    apply_reset();

    // T1: domain 1, put ack on the second SEND cycle, matching reply after a mismatch.
    clear_stim(16);
    s_req[0] = 4'b0010;
    for (int c = 0; c < 16; c++) begin s_pe[c] = 1'b1; s_ge[c] = 1'b1; end
    s_ack[3] = 1'b1;
    s_gv[6] = 1'b1; s_gi[6] = 2'd2;
    s_gv[8] = 1'b1; s_gi[8] = 2'd1;
    run_segment(16);
    check("t1_pre_release", 32'(e_freeze[8]), 32'(4'b1111));
    check("t1_release", 32'(e_freeze[9]), 32'(4'b1101));
    check("t1_after_release", 32'(e_freeze[10]), 32'(4'b1111));
    check("t1_busy_falls", 32'(e_busy[10]), 32'(0));
    check("t1_put_req", 32'(e_preq[2]), 32'(1));
    check("t1_max_wait", 32'(e_maxw[15]), 32'(4));

    // T2: all four domains at once, released in order 0,1,2,3.
    clear_stim(12);
    s_req[0] = 4'b1111;
    run_segment(12);
    check("t2_rel0", 32'(e_freeze[2]), 32'(4'b1110));
    check("t2_gap", 32'(e_freeze[3]), 32'(4'b1111));
    check("t2_rel1", 32'(e_freeze[4]), 32'(4'b1101));
    check("t2_rel2", 32'(e_freeze[6]), 32'(4'b1011));
    check("t2_rel3", 32'(e_freeze[8]), 32'(4'b0111));
    check("t2_xfer_cnt", 32'(e_xcnt[11]), 32'(4));

    // T3: GET sees only mismatched replies; watchdog fires 16 cycles after GET entry.
    clear_stim(30);
    s_req[0] = 4'b0001;
    for (int c = 0; c < 30; c++) begin s_ge[c] = 1'b1; s_gv[c] = 1'b1; s_gi[c] = 2'd2; end
    run_segment(30);
    check("t3_no_err_yet", 32'(e_err[17]), 32'(0));
    check("t3_err_rises", 32'(e_err[18]), 32'(1));
    check("t3_err_latched", 32'(e_err[29]), 32'(1));
    check("t3_frozen", 32'(e_freeze[29]), 32'(4'b1111));

    // T5: reset lands while SEND waits for an ack; domain 3 request must be dropped.
    clear_stim(6);
    s_req[0] = 4'b0001; s_req[1] = 4'b1000;
    for (int c = 0; c < 6; c++) s_pe[c] = 1'b1;
    run_segment(6);
    check("t5_in_send", 32'(e_preq[5]), 32'(1));

    // T4: put and get disabled, domain 2 released two cycles after its pulse.
    clear_stim(8);
    s_req[0] = 4'b0100;
    run_segment(8);
    check("t4_not_yet", 32'(e_freeze[1]), 32'(4'b1111));
    check("t4_release", 32'(e_freeze[2]), 32'(4'b1011));
    check("t4_idle_busy", 32'(e_busy[1]), 32'(0));

    // Randomized segments.
    for (int seg = 0; seg < 30; seg++) begin
      gen_random(300);
      run_segment(300);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
